decode_sequencer: RTL
=====================

DECODE_SEQUENCER -- requirements
Module: decode_sequencer

Interface
REQ-001 The block SHALL have parameter NOP_INS, default 32'h0000_0013, giving the instruction whose decode is presented on all out_* fields while out_valid is low.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset, asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1, fetch presents an instruction.
REQ-005 The block SHALL have port in_ready, output, 1, the block can accept an instruction.
REQ-006 The block SHALL have port in_ins, input, 32, the raw instruction word.
REQ-007 The block SHALL have port in_pc, input, 32, the PC of in_ins.
REQ-008 The block SHALL have port flush, input, 1, the synchronous discard of all buffered entries.
REQ-009 The block SHALL have port out_valid, output, 1, the decoded head entry is valid.
REQ-010 The block SHALL have port out_ready, input, 1, execute accepts the head entry.
REQ-011 The block SHALL have port out_pc, output, 32, the PC of the head entry.
REQ-012 The block SHALL have ports out_opcode (7), out_rd (5), out_funct3 (3), out_rs1 (5), out_rs2 (5) and out_funct7 (7), all outputs, giving the instruction fields at ins[6:0], [11:7], [14:12], [19:15], [24:20] and [31:25].
REQ-013 The block SHALL have port out_imm, output, 32, the sign-extended immediate.
REQ-014 The block SHALL have port out_fmt, output, 3, the format code: R=0, I=1, S=2, B=3, U=4, J=5, illegal=7.
REQ-015 The block SHALL have port out_illegal, output, 1, the head entry has an unrecognised encoding.

Function
REQ-016 The block SHALL contain a 2-entry in-order FIFO of decoded entries with 2-bit occupancy count (0..2), head/tail pointers wrapping modulo 2.
REQ-017 Decode SHALL be combinational on in_ins, with the result written into the tail entry; a push occurs when in_valid and in_ready are high at a clock edge.
REQ-018 in_ready SHALL equal (count < 2) and SHALL NOT depend combinationally on out_ready.
REQ-019 out_valid SHALL equal (count > 0); a pop occurs when out_valid and out_ready are high at a clock edge.
REQ-020 Latency SHALL be one cycle: an entry pushed at edge N with count 0 SHALL be presented with out_valid high from edge N until popped.
REQ-021 A simultaneous push and pop at count 1 SHALL leave count at 1 and advance both pointers; at count 0 a pop is impossible; at count 2 a push is impossible.
REQ-022 While out_valid is high, the head entry SHALL be held stable until popped.
REQ-023 When out_valid is low, all out_* decode fields SHALL equal the decode of NOP_INS, with out_pc = 0.
REQ-024 Opcodes SHALL map to formats as follows: 0110011 -> R; 0010011, 0000011, 1100111, 1110011, 0001111 -> I; 0100011 -> S; 1100011 -> B; 0110111, 0010111 -> U; 1101111 -> J.
REQ-025 Any other opcode SHALL decode as fmt=7, out_illegal=1, out_imm=0, with the raw fields still reported.
REQ-026 The immediates SHALL be: I = sext(ins[31:20]); S = sext({ins[31:25], ins[11:7]}); B = sext({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}); U = {ins[31:12], 12'b0}; J = sext({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}); R -> 0.
REQ-027 A flush SHALL set count to 0 at the next edge, and any push and pop in the same cycle SHALL be ignored.
REQ-028 After a flush, out_valid SHALL be low and in_ready SHALL be high at the next cycle.

Reset
REQ-029 rst_n low SHALL immediately set count, head and tail to 0, giving out_valid=0 and in_ready=1, with out_* equal to the NOP_INS decode.
REQ-030 An assertion of rst_n mid-operation SHALL discard all buffered entries with no partial pop; the first accepted instruction after release SHALL appear as the next head.

Verification
REQ-031 A push of 0xFFF00093 at PC 0x100, with out_ready=1, SHALL produce, one cycle later, out_valid=1, opcode=0x13, rd=1, rs1=0, funct3=0, fmt=1, imm=0xFFFFFFFF and out_pc=0x100.
REQ-032 A push of 0xFE000EE3 (beq x0,x0,-4) SHALL produce fmt=3, imm=0xFFFFFFFC, rs1=0, rs2=0 and out_illegal=0.
REQ-033 With out_ready=0 and three pushes A, B, C attempted, the bench SHALL see A and B accepted with in_ready low while C is held; after out_ready goes high, outputs SHALL appear in order A, B, C with none lost or duplicated.
REQ-034 A push of 0x00000000 SHALL produce out_illegal=1, fmt=7 and imm=0.
REQ-035 flush asserted with count=2 together with in_valid=1 SHALL give, next cycle, out_valid=0, in_ready=1, and no entry from that cycle's push.
REQ-036 rst_n pulsed low asynchronously with count=1 SHALL drop out_valid before the next clock edge, and a subsequent push of 0x00500113 SHALL appear with rd=2 and imm=5.

Source files
------------

// File: rtl/decode_sequencer_if.sv
// Fetch-to-execute channel of the decode sequencer: instruction push side, decoded pop side, flush.
// The slave modport is the sequencer; master is the fetch/execute environment.
interface decode_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_ins;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [6:0]  out_funct7;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_illegal;

    modport master (
        output in_valid, in_ins, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_funct3, out_rs1, out_rs2,
               out_funct7, out_imm, out_fmt, out_illegal
    );

    modport slave (
        input  in_valid, in_ins, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_opcode, out_rd, out_funct3, out_rs1, out_rs2,
               out_funct7, out_imm, out_fmt, out_illegal
    );
endinterface

// File: rtl/decode_sequencer.sv
// RV32 instruction decoder feeding a 2-entry in-order FIFO of decoded entries.
// Decode happens on the way in; the head entry (or the NOP decode when empty) drives the outputs.
module decode_sequencer #(
    parameter logic [31:0] NOP_INS = 32'h0000_0013
) (
    input logic               clk,
    input logic               rst_n,
    decode_sequencer_if.slave bus
);
    localparam logic [2:0] FmtR   = 3'd0;
    localparam logic [2:0] FmtI   = 3'd1;
    localparam logic [2:0] FmtS   = 3'd2;
    localparam logic [2:0] FmtB   = 3'd3;
    localparam logic [2:0] FmtU   = 3'd4;
    localparam logic [2:0] FmtJ   = 3'd5;
    localparam logic [2:0] FmtIll = 3'd7;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        illegal;
    } dec_t;

    typedef struct packed {
        logic [31:0] pc;
        dec_t        dec;
    } entry_t;

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t d;
        d.opcode  = ins[6:0];
        d.rd      = ins[11:7];
        d.funct3  = ins[14:12];
        d.rs1     = ins[19:15];
        d.rs2     = ins[24:20];
        d.funct7  = ins[31:25];
        d.imm     = '0;
        d.fmt     = FmtIll;
        d.illegal = 1'b0;
        case (ins[6:0])
            7'b0110011: d.fmt = FmtR;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: begin
                d.fmt = FmtI;
                d.imm = {{20{ins[31]}}, ins[31:20]};
            end
            7'b0100011: begin
                d.fmt = FmtS;
                d.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            7'b1100011: begin
                d.fmt = FmtB;
                d.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                d.fmt = FmtU;
                d.imm = {ins[31:12], 12'b0};
            end
            7'b1101111: begin
                d.fmt = FmtJ;
                d.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    logic [1:0] count_q, count_d;
    logic       head_q, head_d;
    logic       tail_q, tail_d;
    entry_t     mem_q [2];
    entry_t     head_entry;
    dec_t       in_dec;
    dec_t       nop_dec;
    logic       push;
    logic       pop;

    assign in_dec        = decode(bus.in_ins);
    assign nop_dec       = decode(NOP_INS);
    assign bus.in_ready  = (count_q != 2'd2);
    assign bus.out_valid = (count_q != 2'd0);

    // Flush wins over any handshake in the same cycle.
    assign push = bus.in_valid & bus.in_ready & ~bus.flush;
    assign pop  = bus.out_valid & bus.out_ready & ~bus.flush;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (bus.flush) begin
            count_d = 2'd0;
            head_d  = 1'b0;
            tail_d  = 1'b0;
        end else begin
            if (push) tail_d = ~tail_q;
            if (pop)  head_d = ~head_q;
            unique case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    // Payload storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem_q[tail_q] <= {bus.in_pc, in_dec};
    end

    always_comb begin
        head_entry = {32'h0, nop_dec};
        if (bus.out_valid) head_entry = mem_q[head_q];
    end

    assign bus.out_pc      = head_entry.pc;
    assign bus.out_opcode  = head_entry.dec.opcode;
    assign bus.out_rd      = head_entry.dec.rd;
    assign bus.out_funct3  = head_entry.dec.funct3;
    assign bus.out_rs1     = head_entry.dec.rs1;
    assign bus.out_rs2     = head_entry.dec.rs2;
    assign bus.out_funct7  = head_entry.dec.funct7;
    assign bus.out_imm     = head_entry.dec.imm;
    assign bus.out_fmt     = head_entry.dec.fmt;
    assign bus.out_illegal = head_entry.dec.illegal;
endmodule
